// File: rtl/pipeline_ctrl.sv
// Pipeline stall/flush controller: decodes hazard codes and LSU busy into per-stage
// enables/flushes, sequences the load-use bubble and memory freeze, keeps perf counters.
module pipeline_ctrl #(
  parameter int unsigned CNT_W       = 32,
  parameter int unsigned MEM_TIMEOUT = 64
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [5:0]       hazard_op_i,
  input  logic             lsu_busy_i,
  output logic             pc_en_o,
  output logic             if_id_en_o,
  output logic             if_id_flush_o,
  output logic             id_ex_en_o,
  output logic             id_ex_flush_o,
  output logic             ex_mem_en_o,
  output logic             ex_mem_flush_o,
  output logic             mem_wb_en_o,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic [CNT_W-1:0] flush_cnt_o,
  output logic             err_timeout_o
);

  localparam int unsigned BusyW = $clog2(MEM_TIMEOUT + 1);

  typedef enum logic [1:0] {StRun, StLuStall, StMemWait} state_e;

  state_e             state_q, state_d;
  logic [BusyW-1:0]   busy_cnt_q, busy_cnt_d;
  logic [CNT_W-1:0]   stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0]   flush_cnt_q, flush_cnt_d;
  logic               err_q, err_d;

  logic br, rw, lu, lu_act, br_act;

  // Hazard decode
  assign br = (hazard_op_i == 6'b001111);
  assign rw = (hazard_op_i == 6'b000111);
  assign lu = !br && !rw &&
              ((hazard_op_i[5] && hazard_op_i[3:2] == 2'd2) ||
               (hazard_op_i[4] && hazard_op_i[1:0] == 2'd2));

  // Load-use is masked only in the bubble cycle itself, so a load-use held across a
  // memory freeze is still honoured once the freeze lifts.
  assign lu_act = !lsu_busy_i && lu && (state_q != StLuStall);
  assign br_act = !lsu_busy_i && br;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= StRun;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = StRun;
    if (lsu_busy_i) begin
      state_d = StMemWait;
    end else if (lu_act) begin
      state_d = StLuStall;
    end
  end

  always_comb begin
    pc_en_o        = 1'b1;
    if_id_en_o     = 1'b1;
    if_id_flush_o  = 1'b0;
    id_ex_en_o     = 1'b1;
    id_ex_flush_o  = 1'b0;
    ex_mem_en_o    = 1'b1;
    ex_mem_flush_o = 1'b0;
    mem_wb_en_o    = 1'b1;
    if (rst_i) begin
      pc_en_o        = 1'b0;
      if_id_en_o     = 1'b0;
      if_id_flush_o  = 1'b1;
      id_ex_en_o     = 1'b0;
      id_ex_flush_o  = 1'b1;
      ex_mem_en_o    = 1'b0;
      ex_mem_flush_o = 1'b1;
      mem_wb_en_o    = 1'b0;
    end else if (lsu_busy_i) begin
      pc_en_o     = 1'b0;
      if_id_en_o  = 1'b0;
      id_ex_en_o  = 1'b0;
      ex_mem_en_o = 1'b0;
      mem_wb_en_o = 1'b0;
    end else if (br) begin
      if_id_flush_o = 1'b1;
      id_ex_flush_o = 1'b1;
    end else if (rw) begin
      pc_en_o       = 1'b0;
      if_id_en_o    = 1'b0;
      id_ex_flush_o = 1'b1;
    end else if (lu_act) begin
      pc_en_o        = 1'b0;
      if_id_en_o     = 1'b0;
      id_ex_en_o     = 1'b0;
      ex_mem_flush_o = 1'b1;
    end
  end

  always_comb begin
    busy_cnt_d = '0;
    if (lsu_busy_i) begin
      busy_cnt_d = (busy_cnt_q == BusyW'(MEM_TIMEOUT)) ? busy_cnt_q : busy_cnt_q + BusyW'(1);
    end
    err_d = err_q || (busy_cnt_q == BusyW'(MEM_TIMEOUT));
    stall_cnt_d = stall_cnt_q;
    if (!pc_en_o && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
    flush_cnt_d = flush_cnt_q;
    if (br_act && (flush_cnt_q != '1)) begin
      flush_cnt_d = flush_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      busy_cnt_q  <= '0;
      err_q       <= 1'b0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      busy_cnt_q  <= busy_cnt_d;
      err_q       <= err_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_cnt_o   = stall_cnt_q;
  assign flush_cnt_o   = flush_cnt_q;
  assign err_timeout_o = err_q;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed bench for pipeline_ctrl: per-cycle behavioural model compare plus
// hand-computed literal checks for each scenario.
module tb_pipeline_ctrl;

  localparam int unsigned CntW = 4;
  localparam int unsigned MemTo = 4;

  // {pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush, ex_mem_en, ex_mem_flush, mem_wb_en}
  localparam logic [7:0] VRst = 8'b0010_1010;
  localparam logic [7:0] VRun = 8'b1101_0101;
  localparam logic [7:0] VBr  = 8'b1111_1101;
  localparam logic [7:0] VRw  = 8'b0001_1101;
  localparam logic [7:0] VLu  = 8'b0000_0111;
  localparam logic [7:0] VFrz = 8'b0000_0000;

  logic clk, rst, lsu_busy;
  logic [5:0] hazard_op;
  logic pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush, ex_mem_en, ex_mem_flush, mem_wb_en;
  logic [CntW-1:0] stall_cnt, flush_cnt;
  logic err_timeout;
  logic [7:0] dut_vec;

  int n_checks = 0;
  int n_fail = 0;
  bit done = 0;

  pipeline_ctrl #(.CNT_W(CntW), .MEM_TIMEOUT(MemTo)) dut (
    .clk_i(clk), .rst_i(rst), .hazard_op_i(hazard_op), .lsu_busy_i(lsu_busy),
    .pc_en_o(pc_en), .if_id_en_o(if_id_en), .if_id_flush_o(if_id_flush),
    .id_ex_en_o(id_ex_en), .id_ex_flush_o(id_ex_flush), .ex_mem_en_o(ex_mem_en),
    .ex_mem_flush_o(ex_mem_flush), .mem_wb_en_o(mem_wb_en), .stall_cnt_o(stall_cnt),
    .flush_cnt_o(flush_cnt), .err_timeout_o(err_timeout)
  );

  assign dut_vec = {pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush,
                    ex_mem_en, ex_mem_flush, mem_wb_en};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Behavioural model: action chosen from the priority table; bubble_last marks that the
  // previous cycle inserted a load-use bubble, which masks load-use for one cycle.
  bit m_bubble_last;
  int m_busy_run, m_stall, m_flush;
  bit m_err;
  int cnt_max = (1 << CntW) - 1;

  function automatic logic [7:0] model_vec(input logic [5:0] op, input logic b, input bit last);
    bit is_br, is_rw, is_lu;
    is_br = (op == 6'b001111);
    is_rw = (op == 6'b000111);
    is_lu = !is_br && !is_rw && ((op[5] && op[3:2] == 2) || (op[4] && op[1:0] == 2));
    if (b) return VFrz;
    if (is_br) return VBr;
    if (is_rw) return VRw;
    if (is_lu && !last) return VLu;
    return VRun;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_bubble_last = 0;
      m_busy_run = 0;
      m_stall = 0;
      m_flush = 0;
      m_err = 0;
    end else begin
      logic [7:0] v;
      v = model_vec(hazard_op, lsu_busy, m_bubble_last);
      if (m_busy_run == MemTo) m_err = 1;
      m_busy_run = lsu_busy ? ((m_busy_run < MemTo) ? m_busy_run + 1 : m_busy_run) : 0;
      if (!v[7] && m_stall < cnt_max) m_stall++;
      if (v == VBr && m_flush < cnt_max) m_flush++;
      m_bubble_last = (v == VLu);
    end
  end

  always @(negedge clk) begin
    if (!done) begin
      chk("vec", 32'(dut_vec), rst ? 32'(VRst) : 32'(model_vec(hazard_op, lsu_busy, m_bubble_last)));
      chk("stall_cnt", 32'(stall_cnt), 32'(m_stall));
      chk("flush_cnt", 32'(flush_cnt), 32'(m_flush));
      chk("err", 32'(err_timeout), 32'(m_err));
    end
  end

  task automatic apply(input logic [5:0] op, input logic b);
    hazard_op = op;
    lsu_busy = b;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    hazard_op = '0;
    lsu_busy = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_vec", 32'(dut_vec), 32'(VRst));
    chk("rst_stall", 32'(stall_cnt), 32'd0);
    rst = 1'b0;
    tick();

    // T1 idle
    for (int i = 0; i < 10; i++) begin
      apply(6'b000000, 1'b0);
      chk("t1_vec", 32'(dut_vec), 32'(VRun));
      tick();
    end
    chk("t1_stall", 32'(stall_cnt), 32'd0);

    // T2 load-use, one bubble then masked
    apply(6'b101000, 1'b0);
    chk("t2_bubble", 32'(dut_vec), 32'(VLu));
    tick();
    apply(6'b101000, 1'b0);
    chk("t2_masked", 32'(dut_vec), 32'(VRun));
    tick();
    chk("t2_stall", 32'(stall_cnt), 32'd1);

    // T3 branch flush
    apply(6'b001111, 1'b0);
    chk("t3_br", 32'(dut_vec), 32'(VBr));
    tick();
    chk("t3_flush", 32'(flush_cnt), 32'd1);

    // T4 freeze with pending load-use
    for (int i = 0; i < 3; i++) begin
      apply(6'b010010, 1'b1);
      chk("t4_freeze", 32'(dut_vec), 32'(VFrz));
      tick();
    end
    apply(6'b010010, 1'b0);
    chk("t4_lu", 32'(dut_vec), 32'(VLu));
    tick();
    apply(6'b010010, 1'b0);
    chk("t4_run", 32'(dut_vec), 32'(VRun));
    tick();
    chk("t4_stall", 32'(stall_cnt), 32'd5);

    // T5 timeout
    apply(6'b000000, 1'b0);
    tick();
    chk("t5_err_pre", 32'(err_timeout), 32'd0);
    for (int i = 0; i < 6; i++) begin
      apply(6'b000000, 1'b1);
      chk("t5_err", 32'(err_timeout), (i >= 5) ? 32'd1 : 32'd0);
      tick();
    end
    for (int i = 0; i < 3; i++) begin
      apply(6'b000000, 1'b0);
      chk("t5_sticky", 32'(err_timeout), 32'd1);
      tick();
    end
    rst = 1'b1;
    #1;
    chk("t5_err_rst", 32'(err_timeout), 32'd0);
    @(negedge clk);
    #1;
    rst = 1'b0;
    tick();

    // T6 reset mid load-use stall, then saturation
    apply(6'b101000, 1'b0);
    chk("t6_lu", 32'(dut_vec), 32'(VLu));
    tick();
    apply(6'b101000, 1'b0);
    rst = 1'b1;
    #1;
    chk("t6_rst_vec", 32'(dut_vec), 32'(VRst));
    chk("t6_rst_stall", 32'(stall_cnt), 32'd0);
    hazard_op = 6'b000000;
    @(negedge clk);
    #1;
    rst = 1'b0;
    tick();
    apply(6'b000000, 1'b0);
    chk("t6_first", 32'(dut_vec), 32'(VRun));
    tick();
    for (int i = 0; i < 20; i++) begin
      apply(6'b000111, 1'b0);
      chk("t6_rw", 32'(dut_vec), 32'(VRw));
      tick();
    end
    chk("t6_stall_sat", 32'(stall_cnt), 32'd15);
    for (int i = 0; i < 18; i++) begin
      apply(6'b001111, 1'b0);
      tick();
    end
    chk("t6_flush_sat", 32'(flush_cnt), 32'd15);
    chk("t6_stall_hold", 32'(stall_cnt), 32'd15);

    done = 1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
